// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types for the Wishbone classic master: the access-size encoding seen
// on the request port, the master's FSM states, and a helper that decides
// whether a request may go out on the bus at all.
// ---------------------------------------------------------------------------
package wb_pkg;

    // Access size as encoded on req_size_i; 2'd3 has no member and is rejected.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // A request is legal when its size is known and its address is naturally
    // aligned for that size; anything else is answered with an error and
    // never reaches the bus.
    function automatic logic request_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~addr_lo[0];
            2'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// ---------------------------------------------------------------------------
// wb_lane_align
// Purely combinational byte-lane steering for a 32-bit little-endian bus.
// Outgoing: produces the byte selects and replicates store data onto every
// lane so the responder finds it on whichever lane is selected.
// Incoming: picks the addressed byte/half out of the bus word and sign- or
// zero-extends it to 32 bits.
//
// Ports
//   addr_lo     in   2  low address bits (byte offset within the word)
//   size        in   2  access size (BYTE/HALF/WORD; other values give zeros)
//   zero_ext    in   1  1 = zero-extend loads, 0 = sign-extend
//   store_data  in  32  right-justified store data
//   bus_rdata   in  32  word returned by the responder
//   sel         out  4  byte lane selects
//   bus_wdata   out 32  lane-replicated store data
//   load_data   out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module wb_lane_align
    import wb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        sel       = 4'b0000;
        bus_wdata = 32'h0000_0000;
        load_data = 32'h0000_0000;
        byte_val  = 8'h00;
        half_val  = 16'h0000;
        case (size)
            BYTE: begin
                sel       = 4'b0001 << addr_lo;
                bus_wdata = {4{store_data[7:0]}};
                byte_val  = bus_rdata[{addr_lo, 3'b000} +: 8];
                load_data = zero_ext ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            end
            HALF: begin
                // addr_lo[0] is always 0 here; misaligned halves never reach the bus.
                sel       = 4'b0011 << addr_lo;
                bus_wdata = {2{store_data[15:0]}};
                half_val  = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
                load_data = zero_ext ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            end
            WORD: begin
                sel       = 4'b1111;
                bus_wdata = store_data;
                load_data = bus_rdata;
            end
            default: begin
                sel       = 4'b0000;
                bus_wdata = 32'h0000_0000;
                load_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/wb_master.sv
// ---------------------------------------------------------------------------
// wb_master
// Converts single load/store requests from a core into Wishbone classic
// cycles. One request is in flight at a time: IDLE accepts, BUS holds the
// cycle until ack/err/timeout, RESP emits a one-cycle response strobe.
// Misaligned or bad-size requests skip the bus and go straight to RESP with
// an error.
//
// Parameters
//   ADDR_WIDTH      byte address width on request and bus ports
//   TIMEOUT_CYCLES  BUS cycles to wait for ack/err before giving up (0 = never)
//
// Ports
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i
//                              request fields
//   rsp_valid_o, rsp_rdata_o, rsp_err_o
//                              one-cycle response (rdata 0 for stores/errors)
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
//                              Wishbone master outputs (registered)
//   wb_dat_i, wb_ack_i, wb_err_i
//                              Wishbone responder inputs
// ---------------------------------------------------------------------------
module wb_master
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e          state;
    state_e          state_next;

    logic            saved_we;
    logic            saved_unsigned;
    size_e           saved_size;
    logic [1:0]      saved_addr_lo;
    logic [TW-1:0]   tmo_count;

    logic            accept_ok;
    logic            timeout_hit;
    logic            bus_end;

    logic [1:0]      lane_addr;
    size_e           lane_size;
    logic [3:0]      lane_sel;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_load;

    // Ready is forced low during reset so nothing is accepted on a reset edge.
    assign req_ready_o = (state == IDLE) && !wb_rst_i;
    assign rsp_valid_o = (state == RESP);

    assign accept_ok   = request_ok(req_size_i, req_addr_i[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(tmo_count) == TIMEOUT_CYCLES - 1);
    assign bus_end     = wb_ack_i || wb_err_i || timeout_hit;

    // The single lane aligner serves both directions: in IDLE it looks at the
    // incoming request to build sel/dat, afterwards at the saved request to
    // extract load data from the bus word.
    assign lane_addr = (state == IDLE) ? req_addr_i[1:0] : saved_addr_lo;
    assign lane_size = (state == IDLE) ? size_e'(req_size_i) : saved_size;

    wb_lane_align u_lane_align (
        .addr_lo    (lane_addr),
        .size       (lane_size),
        .zero_ext   (saved_unsigned),
        .store_data (req_wdata_i),
        .bus_rdata  (wb_dat_i),
        .sel        (lane_sel),
        .bus_wdata  (lane_wdata),
        .load_data  (lane_load)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid_i) state_next = accept_ok ? BUS : RESP;
            BUS:  if (bus_end)     state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are loaded on acceptance and held untouched through BUS;
    // the terminating edge clears them and captures the response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_adr_o       <= '0;
            wb_sel_o       <= 4'b0000;
            wb_dat_o       <= 32'h0000_0000;
            rsp_rdata_o    <= 32'h0000_0000;
            rsp_err_o      <= 1'b0;
            saved_we       <= 1'b0;
            saved_unsigned <= 1'b0;
            saved_size     <= BYTE;
            saved_addr_lo  <= 2'b00;
            tmo_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_rdata_o <= 32'h0000_0000;
                    rsp_err_o   <= 1'b0;
                    if (req_valid_i) begin
                        saved_we       <= req_we_i;
                        saved_unsigned <= req_unsigned_i;
                        saved_size     <= size_e'(req_size_i);
                        saved_addr_lo  <= req_addr_i[1:0];
                        tmo_count      <= '0;
                        if (accept_ok) begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= req_we_i;
                            wb_adr_o <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            wb_sel_o <= lane_sel;
                            wb_dat_o <= lane_wdata;
                        end else begin
                            rsp_err_o <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (bus_end) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= '0;
                        wb_sel_o <= 4'b0000;
                        wb_dat_o <= 32'h0000_0000;
                        // err wins over ack; no ack and no err means timeout.
                        rsp_err_o   <= wb_err_i || !wb_ack_i;
                        rsp_rdata_o <= (wb_ack_i && !wb_err_i && !saved_we) ? lane_load : 32'h0000_0000;
                    end else begin
                        tmo_count <= tmo_count + TW'(1);
                    end
                end
                RESP: begin
                    rsp_rdata_o <= 32'h0000_0000;
                    rsp_err_o   <= 1'b0;
                end
                default: begin
                    rsp_rdata_o <= 32'h0000_0000;
                    rsp_err_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// ---------------------------------------------------------------------------
// tb_wb_master
// Directed bench for wb_master with a zero-wait ROM responder holding
// 0xDEADBEEF. The responder's ack/err behaviour is switched per test.
// ---------------------------------------------------------------------------
module tb_wb_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_out;
    logic [31:0] wb_dat_in;
    logic        wb_ack;
    logic        wb_err;

    logic        ack_en;
    logic        err_en;
    logic [31:0] rom_word;

    int checks;
    int failures;

    logic        obs_ready;
    logic        obs_cyc1;
    logic        obs_stb1;
    logic        obs_we1;
    logic [3:0]  obs_sel1;
    logic [31:0] obs_adr1;
    logic [31:0] obs_dat1;
    int          obs_stb_cycles;
    logic        obs_cyc_seen;
    int          obs_rsp_cycle;
    logic [31:0] obs_rsp_rdata;
    logic        obs_rsp_err;
    logic        obs_rsp_after;

    wb_master #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .wb_cyc_o       (wb_cyc),
        .wb_stb_o       (wb_stb),
        .wb_we_o        (wb_we),
        .wb_adr_o       (wb_adr),
        .wb_sel_o       (wb_sel),
        .wb_dat_o       (wb_dat_out),
        .wb_dat_i       (wb_dat_in),
        .wb_ack_i       (wb_ack),
        .wb_err_i       (wb_err)
    );

    // Zero-wait responder: answers in the same cycle the strobe is seen.
    assign wb_ack    = wb_cyc & wb_stb & ack_en;
    assign wb_err    = wb_cyc & wb_stb & err_en;
    assign wb_dat_in = rom_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Issues one request and records what the bus and response did. Cycle 0
    // is the accepting cycle; cycle numbers in obs_rsp_cycle count from it.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
        int waited;
        obs_ready      = 1'b0;
        obs_cyc1       = 1'b0;
        obs_stb1       = 1'b0;
        obs_we1        = 1'b0;
        obs_sel1       = 4'h0;
        obs_adr1       = 32'h0;
        obs_dat1       = 32'h0;
        obs_stb_cycles = 0;
        obs_cyc_seen   = 1'b0;
        obs_rsp_cycle  = -1;
        obs_rsp_rdata  = 32'h0;
        obs_rsp_err    = 1'b0;
        obs_rsp_after  = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready && waited < 10);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        obs_ready    = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obs_cyc1 = wb_cyc;
                obs_stb1 = wb_stb;
                obs_we1  = wb_we;
                obs_sel1 = wb_sel;
                obs_adr1 = wb_adr;
                obs_dat1 = wb_dat_out;
            end
            if (wb_cyc) obs_cyc_seen = 1'b1;
            if (wb_stb) obs_stb_cycles++;
            if (obs_rsp_cycle >= 0) begin
                obs_rsp_after = rsp_valid;
                break;
            end
            if (rsp_valid) begin
                obs_rsp_cycle = c;
                obs_rsp_rdata = rsp_rdata;
                obs_rsp_err   = rsp_err;
            end
        end
    endtask

    // Common checks for a load that completes on a zero-wait bus.
    task automatic checkLoad(input string tag, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] rdata);
        checkOutput({tag, "_ready"}, 32'(obs_ready), 32'd1);
        checkOutput({tag, "_stb1"}, 32'(obs_stb1), 32'd1);
        checkOutput({tag, "_we"}, 32'(obs_we1), 32'd0);
        checkOutput({tag, "_sel"}, 32'(obs_sel1), 32'(sel));
        checkOutput({tag, "_adr"}, obs_adr1, adr);
        checkOutput({tag, "_rspcyc"}, 32'(obs_rsp_cycle), 32'd2);
        checkOutput({tag, "_rdata"}, obs_rsp_rdata, rdata);
        checkOutput({tag, "_err"}, 32'(obs_rsp_err), 32'd0);
        checkOutput({tag, "_oneshot"}, 32'(obs_rsp_after), 32'd0);
    endtask

    // Common checks for a request rejected before the bus.
    task automatic checkReject(input string tag);
        checkOutput({tag, "_nocyc"}, 32'(obs_cyc_seen), 32'd0);
        checkOutput({tag, "_rspcyc"}, 32'(obs_rsp_cycle), 32'd1);
        checkOutput({tag, "_err"}, 32'(obs_rsp_err), 32'd1);
        checkOutput({tag, "_rdata"}, obs_rsp_rdata, 32'h0);
    endtask

    initial begin
        int pulses;
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        ack_en       = 1'b1;
        err_en       = 1'b0;
        rom_word     = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_cyc", 32'(wb_cyc), 32'd0);
        checkOutput("rst_stb", 32'(wb_stb), 32'd0);
        checkOutput("rst_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        checkLoad("ldw", 4'b1111, 32'h10, 32'hDEAD_BEEF);

        applyStimulus(1'b0, 32'h0000_0013, 2'd0, 1'b0, 32'h0);
        checkLoad("ldb_s13", 4'b1000, 32'h10, 32'hFFFF_FFDE);

        applyStimulus(1'b0, 32'h0000_0013, 2'd0, 1'b1, 32'h0);
        checkLoad("ldb_u13", 4'b1000, 32'h10, 32'h0000_00DE);

        applyStimulus(1'b0, 32'h0000_0010, 2'd0, 1'b0, 32'h0);
        checkLoad("ldb_s10", 4'b0001, 32'h10, 32'hFFFF_FFEF);

        applyStimulus(1'b0, 32'h0000_0011, 2'd0, 1'b1, 32'h0);
        checkLoad("ldb_u11", 4'b0010, 32'h10, 32'h0000_00BE);

        applyStimulus(1'b0, 32'h0000_0012, 2'd1, 1'b0, 32'h0);
        checkLoad("ldh_s12", 4'b1100, 32'h10, 32'hFFFF_DEAD);

        applyStimulus(1'b0, 32'h0000_0010, 2'd1, 1'b1, 32'h0);
        checkLoad("ldh_u10", 4'b0011, 32'h10, 32'h0000_BEEF);

        applyStimulus(1'b1, 32'h0000_0022, 2'd1, 1'b0, 32'h1234_ABCD);
        checkOutput("sth_sel", 32'(obs_sel1), 32'h0000_000C);
        checkOutput("sth_dat", obs_dat1, 32'hABCD_ABCD);
        checkOutput("sth_we", 32'(obs_we1), 32'd1);
        checkOutput("sth_adr", obs_adr1, 32'h20);
        checkOutput("sth_rspcyc", 32'(obs_rsp_cycle), 32'd2);
        checkOutput("sth_rdata", obs_rsp_rdata, 32'h0);
        checkOutput("sth_err", 32'(obs_rsp_err), 32'd0);

        applyStimulus(1'b1, 32'h0000_0031, 2'd0, 1'b0, 32'hFFFF_FF5A);
        checkOutput("stb_sel", 32'(obs_sel1), 32'h0000_0002);
        checkOutput("stb_dat", obs_dat1, 32'h5A5A_5A5A);
        checkOutput("stb_adr", obs_adr1, 32'h30);

        applyStimulus(1'b0, 32'h0000_0002, 2'd2, 1'b0, 32'h0);
        checkReject("misw");
        applyStimulus(1'b0, 32'h0000_0021, 2'd1, 1'b0, 32'h0);
        checkReject("mish");
        applyStimulus(1'b0, 32'h0000_0000, 2'd3, 1'b0, 32'h0);
        checkReject("badsz");

        ack_en = 1'b0;
        applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        checkOutput("tmo_stb", 32'(obs_stb_cycles), 32'd4);
        checkOutput("tmo_rspcyc", 32'(obs_rsp_cycle), 32'd5);
        checkOutput("tmo_err", 32'(obs_rsp_err), 32'd1);
        checkOutput("tmo_rdata", obs_rsp_rdata, 32'h0);

        ack_en = 1'b1;
        err_en = 1'b1;
        applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        checkOutput("ackerr_rspcyc", 32'(obs_rsp_cycle), 32'd2);
        checkOutput("ackerr_err", 32'(obs_rsp_err), 32'd1);
        checkOutput("ackerr_rdata", obs_rsp_rdata, 32'h0);

        ack_en = 1'b0;
        applyStimulus(1'b1, 32'h0000_0014, 2'd2, 1'b0, 32'h1111_2222);
        checkOutput("err_rspcyc", 32'(obs_rsp_cycle), 32'd2);
        checkOutput("err_err", 32'(obs_rsp_err), 32'd1);
        err_en = 1'b0;

        // Reset during the second BUS cycle of a stalled load.
        pulses = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h0000_0010;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        checkOutput("mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_cyc1", 32'(wb_cyc), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_cyc", 32'(wb_cyc), 32'd0);
        checkOutput("mid_stb", 32'(wb_stb), 32'd0);
        checkOutput("mid_ready_rst", 32'(req_ready), 32'd0);
        if (rsp_valid) pulses++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checkOutput("mid_norsp", 32'(pulses), 32'd0);

        ack_en = 1'b1;
        applyStimulus(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        checkLoad("post_rst", 4'b1111, 32'h10, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
